// File: rtl/ttfir_prog.sv
// ttfir_prog: direct-form FIR with run-time loadable signed coefficients.
//
// Each run cycle shifts x_in into the delay line and forms the full-precision
// sum of h[k]*d[k], where d[0] is the live x_in sample. The sum is rounded
// half-up by an arithmetic right shift of SHIFT bits, clamped to the signed
// BW_out range, and registered. A load cycle shifts coef_in into the
// coefficient chain at h[0] and freezes the delay line and both outputs.
// Reset restores the identity filter (h[0] = 1<<SHIFT, all other taps 0).
//
// Ports:
//   clk      in   clock, all state on the rising edge
//   rst      in   asynchronous active-high reset
//   load     in   1 = coefficient load cycle, 0 = filter run cycle
//   coef_in  in   [BW_coef-1:0] signed coefficient word, used when load=1
//   x_in     in   [BW_in-1:0]   signed input sample, used when load=0
//   y_out    out  [BW_out-1:0]  signed filtered output, registered
//   sat_flag out  registered; 1 when the current y_out was clipped

// One tap product, sized so that it is always exact.
module ttfir_tap #(
    parameter int BW_in   = 6,
    parameter int BW_coef = 4
) (
    input  logic [BW_in-1:0]         x,
    input  logic [BW_coef-1:0]       h,
    output logic [BW_in+BW_coef-1:0] p
);
    logic signed [BW_in+BW_coef-1:0] prod;

    // Both operands are signed, so they are sign-extended to the product width.
    assign prod = $signed(x) * $signed(h);
    assign p    = prod;
endmodule

module ttfir_prog #(
    parameter int N_TAPS  = 5,
    parameter int BW_in   = 6,
    parameter int BW_coef = 4,
    parameter int BW_out  = 8,
    parameter int SHIFT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BW_coef-1:0] coef_in,
    input  logic [BW_in-1:0]   x_in,
    output logic [BW_out-1:0]  y_out,
    output logic               sat_flag
);
    localparam int PW    = BW_in + BW_coef;
    localparam int ACC_W = PW + $clog2(N_TAPS);
    // One spare bit so adding the rounding constant can never wrap.
    localparam int SW    = ACC_W + 1;

    localparam logic signed [SW-1:0] YMAX = SW'((2 ** (BW_out - 1)) - 1);
    localparam logic signed [SW-1:0] YMIN = SW'(-(2 ** (BW_out - 1)));

    logic [N_TAPS-1:0][BW_coef-1:0] h;
    logic [N_TAPS-1:1][BW_in-1:0]   dreg;
    logic [N_TAPS-1:0][BW_in-1:0]   taps;
    logic [N_TAPS-1:0][PW-1:0]      prod;

    logic signed [ACC_W-1:0] acc;
    logic signed [SW-1:0]    accx;
    logic signed [SW-1:0]    r;
    logic [BW_out-1:0]       y_nxt;
    logic                    sat_nxt;

    // Tap 0 reads the live sample, so a new x_in reaches y_out on its own edge.
    assign taps = {dreg, x_in};

    genvar k;
    generate
        for (k = 0; k < N_TAPS; k++) begin : g_tap
            ttfir_tap #(.BW_in(BW_in), .BW_coef(BW_coef)) u_tap (
                .x (taps[k]),
                .h (h[k]),
                .p (prod[k])
            );
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int i = 0; i < N_TAPS; i++)
            acc = acc + {{(ACC_W - PW){prod[i][PW-1]}}, prod[i]};
    end

    assign accx = {acc[ACC_W-1], acc};

    generate
        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [SW-1:0] HALF = SW'(1) <<< (SHIFT - 1);
            // Arithmetic shift floors, so adding half first rounds half up.
            assign r = (accx + HALF) >>> SHIFT;
        end else begin : g_nornd
            assign r = accx;
        end
    endgenerate

    always_comb begin
        y_nxt   = r[BW_out-1:0];
        sat_nxt = 1'b0;
        if (r > YMAX) begin
            y_nxt   = YMAX[BW_out-1:0];
            sat_nxt = 1'b1;
        end else if (r < YMIN) begin
            y_nxt   = YMIN[BW_out-1:0];
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h        <= '0;
            h[0]     <= BW_coef'(1 << SHIFT);
            dreg     <= '0;
            y_out    <= '0;
            sat_flag <= 1'b0;
        end else if (load) begin
            // Oldest word migrates toward h[N_TAPS-1]; datapath state holds.
            h <= {h[N_TAPS-2:0], coef_in};
        end else begin
            dreg     <= taps[N_TAPS-2:0];
            y_out    <= y_nxt;
            sat_flag <= sat_nxt;
        end
    end
endmodule

// File: tb/tb_ttfir_prog.sv
module tb_ttfir_prog;
    localparam int N_TAPS  = 5;
    localparam int BW_in   = 6;
    localparam int BW_coef = 4;
    localparam int BW_out  = 8;
    localparam int SHIFT   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load = 1'b0;
    logic [BW_coef-1:0] coef_in = '0;
    logic [BW_in-1:0]   x_in = '0;
    logic [BW_out-1:0]  y_out;
    logic               sat_flag;

    ttfir_prog #(
        .N_TAPS(N_TAPS), .BW_in(BW_in), .BW_coef(BW_coef),
        .BW_out(BW_out), .SHIFT(SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .coef_in  (coef_in),
        .x_in     (x_in),
        .y_out    (y_out),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int y;
        bit s;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: coefficient list (index 0 = h[0]), sample history
    // (index 0 = newest sample), and the last produced output.
    int hm[$];
    int hist[$];
    int ym;
    bit sm;

    always @(posedge clk) cyc++;

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        hm.delete();
        hist.delete();
        for (int i = 0; i < N_TAPS; i++) begin
            hm.push_back(i == 0 ? (1 << SHIFT) : 0);
            hist.push_back(0);
        end
        ym = 0;
        sm = 0;
    endtask

    task automatic model_run(input int x);
        int acc, r, lo, hi;
        hist.push_front(x);
        void'(hist.pop_back());
        acc = 0;
        for (int i = 0; i < N_TAPS; i++) acc += hm[i] * hist[i];
        r  = (SHIFT > 0) ? fdiv(acc + (1 << SHIFT) / 2, 1 << SHIFT) : acc;
        hi = (1 << (BW_out - 1)) - 1;
        lo = -(1 << (BW_out - 1));
        ym = (r > hi) ? hi : (r < lo) ? lo : r;
        sm = (ym != r);
    endtask

    task automatic model_load(input int c);
        hm.push_front(c);
        void'(hm.pop_back());
    endtask

    // Each task drives one edge and queues what the outputs must be after it.
    task automatic run(input int x);
        exp_t e;
        int   xv;
        xv   = x;
        load = 1'b0;
        x_in = xv[BW_in-1:0];
        coef_in = BW_coef'($urandom);
        model_run(x);
        e.cyc = cyc + 1; e.y = ym; e.s = sm;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic ld(input int c);
        exp_t e;
        int   cv;
        cv      = c;
        load    = 1'b1;
        coef_in = cv[BW_coef-1:0];
        x_in    = BW_in'($urandom);
        model_load(c);
        e.cyc = cyc + 1; e.y = ym; e.s = sm;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic check_now(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Async reset pulsed between edges; outputs must clear without an edge.
    task automatic async_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_now("async_rst_y", $signed(y_out), 0);
        check_now("async_rst_sat", int'(sat_flag), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: outputs are registered, so every edge presents a response.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ($signed(y_out) != e.y || sat_flag != e.s) begin
                errors++;
                $display("FAIL y_out@cyc%0d: got y=%0d sat=%0d, expected y=%0d sat=%0d",
                         e.cyc, $signed(y_out), sat_flag, e.y, e.s);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_y", $signed(y_out), 0);
        check_now("reset_sat", int'(sat_flag), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: identity passthrough after reset
        run(5); run(-32); run(31);

        // 2: moving sum
        repeat (5) run(0);
        repeat (5) ld(4);
        repeat (6) run(10);

        // 5: load freeze mid-stream
        repeat (5) run(0);
        run(10); run(10); run(10);
        repeat (5) ld(4);
        run(10); run(10);

        // 3: saturation both ways
        repeat (5) ld(7);
        repeat (6) run(31);
        repeat (6) run(-32);

        // 4: rounding half up with h[0]=1
        ld(0); ld(0); ld(0); ld(0); ld(1);
        repeat (5) run(0);
        run(6); run(5); run(-6); run(-7);

        // 6: async reset mid-load restores identity
        ld(3); ld(-2); ld(5);
        async_reset();
        run(-9); run(17);

        // randomized mix of loads, runs and occasional resets
        for (int n = 0; n < 400; n++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p < 20)      ld($urandom_range(0, 15) - 8);
            else if (p < 22) async_reset();
            else             run($urandom_range(0, 63) - 32);
        end

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
